// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: round-robin frame arbiter in front of the shared
// RAM_ctrl/LCD_control refresh pipeline (100 kHz LCD clock domain).
// Source 0 is the game board, source 1 is the status/score overlay.
// Whole frames are granted, and the winner's table is snapshotted for the frame.
// Frame end (done or timeout) is followed by an optional hold-off.
//
// Ports:
//   clk          LCD-domain clock (clk_div)
//   rst_n        asynchronous active-low reset
//   req[1:0]     level requests (bit0 game board, bit1 overlay)
//   src0_table   game board frame
//   src1_table   overlay frame
//   frame_done   one-cycle pulse when the pipeline wrote the last byte
//   grant[1:0]   one-hot owner of the current frame
//   ack[1:0]     one-cycle pulse on the owner's bit at normal completion
//   frame_table  latched snapshot driven to RAM_ctrl game_table
//   frame_start  one-cycle pulse starting a frame (RAM_ctrl change)
//   busy         high from grant until hold-off ends
//   timeout_err  sticky timeout flag, cleared by the next normal frame_done
module lcd_frame_arbiter #(
  parameter int unsigned WIDTH          = 100,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] src0_table,
  input  logic [WIDTH-1:0] src1_table,
  input  logic             frame_done,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] frame_table,
  output logic             frame_start,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam bit               HOLD_EN   = (HOLDOFF_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [1:0]       r_grant;
  logic [1:0]       r_ack;
  logic [WIDTH-1:0] r_table;
  logic             r_start;
  logic             r_busy;
  logic             r_err;

  logic             w_win;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_frame_end;

  // Winner index: on a tie the source that did not own the previous frame wins.
  always_comb begin
    w_win = req[1];
    if (req == 2'b11) w_win = ~r_last;
  end

  // Saturating counter increment.
  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  // Frame ends on a done pulse or when the wait budget is spent.
  assign w_frame_end = frame_done || (r_cnt == TO_LAST);

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
      r_ack   <= 2'b00;
      r_table <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_table <= w_win ? src1_table : src0_table;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_frame_end) begin
            r_grant <= 2'b00;
            r_last  <= r_grant[1];
            r_cnt   <= '0;
            // A done on the timeout edge still counts as a normal completion.
            if (frame_done) begin
              r_ack <= r_grant;
              r_err <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
            if (HOLD_EN) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign ack         = r_ack;
  assign frame_table = r_table;
  assign frame_start = r_start;
  assign busy        = r_busy;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Directed bench for lcd_frame_arbiter with TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=4.
module tb_lcd_frame_arbiter;

  localparam int unsigned WIDTH = 100;
  localparam int unsigned TO    = 100;
  localparam int unsigned HO    = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [WIDTH-1:0] src0_table;
  logic [WIDTH-1:0] src1_table;
  logic             frame_done;
  logic [1:0]       grant;
  logic [1:0]       ack;
  logic [WIDTH-1:0] frame_table;
  logic             frame_start;
  logic             busy;
  logic             timeout_err;

  int n_cmp;
  int n_mis;

  lcd_frame_arbiter #(
    .WIDTH(WIDTH), .CNT_W(16), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .src0_table(src0_table), .src1_table(src1_table),
    .frame_done(frame_done), .grant(grant), .ack(ack),
    .frame_table(frame_table), .frame_start(frame_start),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a grant, check owner and gap, then return done `len` edges after start.
  task automatic run_frame(input string tag, input logic [1:0] exp_g,
                           input int exp_gap, input int len);
    int k;
    k = 0;
    while (grant == 2'b00 && k < 300) begin
      step(1);
      k++;
    end
    chk({tag, "_gap"}, 128'(k), 128'(exp_gap));
    chk({tag, "_grant"}, 128'(grant), 128'(exp_g));
    step(len - 1);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    chk({tag, "_ack"}, 128'(ack), 128'(exp_g));
    chk({tag, "_grant_off"}, 128'(grant), 128'd0);
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    req = 2'b00;
    src0_table = '0;
    src1_table = '0;
    frame_done = 1'b0;

    // Reset state.
    step(2);
    chk("rst_grant", 128'(grant), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_table", 128'(frame_table), 128'd0);
    chk("rst_err", 128'(timeout_err), 128'd0);
    rst_n = 1'b1;
    step(1);

    // Single request from source 0, done 20 cycles after start.
    src0_table = WIDTH'(100'h5);
    src1_table = WIDTH'(100'hC);
    req = 2'b01;
    step(1);
    chk("t1_grant", 128'(grant), 128'd1);
    chk("t1_start", 128'(frame_start), 128'd1);
    chk("t1_table", 128'(frame_table), 128'h5);
    chk("t1_busy", 128'(busy), 128'd1);
    req = 2'b00;
    step(1);
    chk("t1_start_low", 128'(frame_start), 128'd0);
    src0_table = WIDTH'(100'hA);
    step(18);
    chk("t1_frozen_grant", 128'(grant), 128'd1);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    chk("t1_ack", 128'(ack), 128'd1);
    chk("t1_grant_off", 128'(grant), 128'd0);
    chk("t1_table_frozen", 128'(frame_table), 128'h5);
    step(1);
    chk("t1_ack_pulse", 128'(ack), 128'd0);
    step(2);
    chk("t1_busy_hold", 128'(busy), 128'd1);
    step(1);
    chk("t1_busy_fall", 128'(busy), 128'd0);

    // Next grant picks up the new source 0 table.
    req = 2'b01;
    step(1);
    chk("t2_grant", 128'(grant), 128'd1);
    chk("t2_table", 128'(frame_table), 128'hA);
    run_frame("t2", 2'b01, 0, 3);

    // Both held: alternate starting with source 1 after source 0 owned last.
    req = 2'b11;
    run_frame("rr1", 2'b10, HO + 1, 5);
    run_frame("rr2", 2'b01, HO + 1, 5);
    run_frame("rr3", 2'b10, HO + 1, 5);
    req = 2'b00;
    step(HO + 2);
    chk("rr_idle_busy", 128'(busy), 128'd0);

    // Timeout: source 0 wins the tie, never done.
    req = 2'b11;
    step(1);
    chk("to_grant", 128'(grant), 128'd1);
    k = 0;
    while (grant != 2'b00 && k < 300) begin
      step(1);
      k++;
    end
    chk("to_cycles", 128'(k), 128'(TO));
    chk("to_err", 128'(timeout_err), 128'd1);
    chk("to_no_ack", 128'(ack), 128'd0);
    // Source 1 next; its done coincides with the timeout edge.
    run_frame("to_next", 2'b10, HO + 1, TO);
    chk("to_err_clr", 128'(timeout_err), 128'd0);
    req = 2'b00;
    step(HO + 2);

    // frame_done in IDLE is ignored.
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    chk("idle_done_ack", 128'(ack), 128'd0);
    chk("idle_done_busy", 128'(busy), 128'd0);
    chk("idle_done_err", 128'(timeout_err), 128'd0);

    // frame_done in the start cycle is ignored; dropped req still acked.
    req = 2'b01;
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    req = 2'b00;
    chk("sc_grant", 128'(grant), 128'd1);
    step(1);
    chk("sc_no_ack", 128'(ack), 128'd0);
    chk("sc_still_granted", 128'(grant), 128'd1);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    chk("sc_ack", 128'(ack), 128'd1);
    step(HO + 1);

    // Reset mid-WAIT aborts at once.
    req = 2'b11;
    step(1);
    chk("mr_grant", 128'(grant), 128'd2);
    step(3);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_grant_rst", 128'(grant), 128'd0);
    chk("mr_busy_rst", 128'(busy), 128'd0);
    chk("mr_table_rst", 128'(frame_table), 128'd0);
    chk("mr_ack_rst", 128'(ack), 128'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("mr_first_grant", 128'(grant), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
